alu_self_checker: RTL and testbench
===================================

ALU_SELF_CHECKER -- requirements
Module: alu_self_checker

Interface
REQ-001 Parameter VECTORS_PER_OP, default 16: number of random vectors applied per opcode, legal range 1..255.
REQ-002 Parameter SEED, default 16'hACE1: LFSR load value; a SEED of 0 SHALL be replaced by 16'h0001.
REQ-003 Port clk  input  1: single clock, all state updates on the rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port start  input  1: one-cycle request to run a full test pass, sampled only in IDLE.
REQ-006 Port alu_a  output  16: A operand driven to the ALU under test.
REQ-007 Port alu_b  output  16: B operand driven to the ALU under test.
REQ-008 Port alu_opcode  output  8: opcode driven to the ALU under test.
REQ-009 Port alu_c  input  16: ALU result C.
REQ-010 Port alu_flags  input  5: ALU Flags[4:0]; captured on failure only, never compared.
REQ-011 Port busy  output  1: high while a test pass is in progress.
REQ-012 Port done  output  1: high from pass completion until the next accepted start or reset.
REQ-013 Port pass  output  1: valid while done is high; 1 if err_count is 0.
REQ-014 Port err_count  output  8: mismatch count, saturates at 255.
REQ-015 Port fail_a, fail_b, fail_c  output  16 each; fail_op  output  8; fail_flags  output  5: operands, observed result and flags of the first mismatch.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-017 In IDLE or DONE, start=1 SHALL move the FSM to DRIVE, set busy, clear done, err_count and fail_* fields, reload the LFSR with SEED, and select opcode index 0 and vector index 0.
REQ-018 The opcode sequence SHALL be 8'h05 (ADD), 8'h01 (AND), 8'h02 (OR), 8'h03 (XOR).
REQ-019 For each opcode, vectors 0..3 SHALL be the corner pairs (A,B) = (0000,0000), (FFFF,FFFF), (0000,FFFF), (FFFF,0000), in hex.
REQ-020 For each opcode, vectors 4..VECTORS_PER_OP+3 SHALL be random: A = current LFSR value, LFSR advances, B = new value, LFSR advances.
REQ-021 The LFSR SHALL be a 16-bit Galois LFSR with mask 16'hB400 that shifts right and XORs the mask when the output bit is 1; it advances only in DRIVE.
REQ-022 DRIVE SHALL register alu_a, alu_b and alu_opcode, then go to SETTLE; SETTLE SHALL hold them for one cycle, then go to CHECK.
REQ-023 CHECK SHALL compare alu_c against the golden value: ADD = (A+B) mod 2^16, AND = A&B, OR = A|B, XOR = A^B.
REQ-024 On a mismatch, err_count SHALL increment (saturating at 255); if it was 0, fail_* SHALL capture the applied A, B, opcode, alu_c and alu_flags.
REQ-025 After CHECK, the FSM SHALL go to DRIVE for the next vector or opcode, or to DONE after the last vector of XOR.
REQ-026 Each vector SHALL take exactly 3 cycles; a pass SHALL keep busy high for 12*(VECTORS_PER_OP+4) cycles (240 at the default).
REQ-027 In DONE, busy=0, done=1 and pass=(err_count==0); all outputs SHALL hold until start or reset.
REQ-028 start while busy SHALL be ignored; alu_* outputs SHALL hold their last values in IDLE and DONE.

Reset
REQ-029 reset SHALL take priority over start and override all other behaviour.
REQ-030 reset SHALL put the FSM in IDLE; clear busy, done, pass, err_count, fail_* and alu_*; and load the LFSR with SEED.
REQ-031 reset asserted mid-pass SHALL abort the pass with no partial done or pass indication.

Verification
REQ-032 With a correct ALU model and the default parameters, pulse start -> busy high for 240 cycles, then done=1, pass=1, err_count=0.
REQ-033 With an ALU whose ADD returns A+B+1, run a pass -> err_count=20, pass=0, fail_op=05, fail_a=0000, fail_b=0000, fail_c=0001.
REQ-034 With an ALU whose XOR output bit 0 is stuck at 0, run a pass -> first failure fail_op=03, fail_a=0000, fail_b=FFFF, fail_c=FFFE.
REQ-035 Assert reset 50 cycles into a pass -> next cycle busy=0, done=0, err_count=0, alu_a=0; a new start then completes normally in 240 cycles.
REQ-036 Pulse start during busy -> no restart, done at cycle 240; with SEED=0 the first random A is 16'h0001.
REQ-037 With VECTORS_PER_OP=255 and a constantly wrong ALU -> err_count saturates at 255 and does not wrap.

Source files
------------

// File: rtl/alu_self_checker_if.sv
// ALU stimulus/response bus between the self-checker (master) and
// the ALU under test (slave): operands, opcode, result and flags.
interface alu_self_checker_if;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_c;
  logic [4:0]  alu_flags;

  modport master (
    output alu_a, alu_b, alu_opcode,
    input  alu_c, alu_flags
  );

  modport slave (
    input  alu_a, alu_b, alu_opcode,
    output alu_c, alu_flags
  );
endinterface

// File: rtl/alu_self_checker.sv
// Built-in self-checker for a 16-bit ALU: drives corner and LFSR
// vectors for ADD/AND/OR/XOR and counts result mismatches.
// Ports: clk, reset (sync, high), start; alu (master bus);
// busy/done/pass status; err_count; fail_* first-mismatch capture.
module alu_self_checker #(
  parameter int          VECTORS_PER_OP = 16,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  alu_self_checker_if.master  alu,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          err_count,
  output logic [15:0]         fail_a,
  output logic [15:0]         fail_b,
  output logic [15:0]         fail_c,
  output logic [7:0]          fail_op,
  output logic [4:0]          fail_flags
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'h0001 : SEED;
  localparam logic [15:0] MASK     = 16'hB400;
  localparam logic [8:0]  LAST     = 9'(VECTORS_PER_OP + 3);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_op;
  logic [8:0]  r_vec;
  logic [15:0] r_lfsr;
  logic [15:0] r_a, r_b;
  logic [7:0]  r_opc;
  logic [7:0]  r_err;
  logic [15:0] r_fa, r_fb, r_fc;
  logic [7:0]  r_fop;
  logic [4:0]  r_ff;

  logic [15:0] w_step1, w_step2, w_gold;
  logic [7:0]  w_opc;
  logic        w_last, w_mis;

  function automatic logic [15:0] f_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? MASK : 16'h0000);
  endfunction

  assign w_step1 = f_step(r_lfsr);
  assign w_step2 = f_step(w_step1);
  assign w_last  = (r_op == 2'd3) && (r_vec == LAST);

  always_comb begin
    w_opc  = 8'h05;
    w_gold = r_a + r_b;
    unique case (r_op)
      2'd0: begin w_opc = 8'h05; w_gold = r_a + r_b; end
      2'd1: begin w_opc = 8'h01; w_gold = r_a & r_b; end
      2'd2: begin w_opc = 8'h02; w_gold = r_a | r_b; end
      2'd3: begin w_opc = 8'h03; w_gold = r_a ^ r_b; end
      default: ;
    endcase
  end

  assign w_mis = (alu.alu_c != w_gold);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_DRIVE;
      S_DRIVE:  w_next = S_SETTLE;
      S_SETTLE: w_next = S_CHECK;
      S_CHECK:  w_next = w_last ? S_DONE : S_DRIVE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= 2'd0;
      r_vec   <= 9'd0;
      r_lfsr  <= SEED_EFF;
      r_a     <= 16'h0;
      r_b     <= 16'h0;
      r_opc   <= 8'h0;
      r_err   <= 8'h0;
      r_fa    <= 16'h0;
      r_fb    <= 16'h0;
      r_fc    <= 16'h0;
      r_fop   <= 8'h0;
      r_ff    <= 5'h0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_op   <= 2'd0;
            r_vec  <= 9'd0;
            r_lfsr <= SEED_EFF;
            r_err  <= 8'h0;
            r_fa   <= 16'h0;
            r_fb   <= 16'h0;
            r_fc   <= 16'h0;
            r_fop  <= 8'h0;
            r_ff   <= 5'h0;
          end
        end
        S_DRIVE: begin
          r_opc <= w_opc;
          if (r_vec < 9'd4) begin
            // corners: (0,0) (F,F) (0,F) (F,0)
            r_a <= {16{r_vec[0]}};
            r_b <= {16{r_vec[0] ^ r_vec[1]}};
          end else begin
            r_a    <= r_lfsr;
            r_b    <= w_step1;
            r_lfsr <= w_step2;
          end
        end
        S_CHECK: begin
          if (w_mis) begin
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
            if (r_err == 8'h0) begin
              r_fa  <= r_a;
              r_fb  <= r_b;
              r_fc  <= alu.alu_c;
              r_fop <= r_opc;
              r_ff  <= alu.alu_flags;
            end
          end
          if (r_vec == LAST) begin
            r_vec <= 9'd0;
            r_op  <= r_op + 2'd1;
          end else begin
            r_vec <= r_vec + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu.alu_a      = r_a;
  assign alu.alu_b      = r_b;
  assign alu.alu_opcode = r_opc;

  assign busy = (r_state == S_DRIVE) || (r_state == S_SETTLE) ||
                (r_state == S_CHECK);
  assign done = (r_state == S_DONE);
  assign pass = done && (r_err == 8'h0);

  assign err_count  = r_err;
  assign fail_a     = r_fa;
  assign fail_b     = r_fb;
  assign fail_c     = r_fc;
  assign fail_op    = r_fop;
  assign fail_flags = r_ff;

endmodule

// File: tb/tb_alu_self_checker.sv
// Testbench for alu_self_checker: behavioural ALU with injectable
// faults, table-driven passes plus reset-abort and saturation runs.
module tb_alu_self_checker;

  logic clk = 1'b0;
  logic reset;
  logic start0, start1;
  int   mode0, mode1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  alu_self_checker_if if0 ();
  alu_self_checker_if if1 ();

  logic        busy0, done0, pass0;
  logic [7:0]  err0, fop0;
  logic [15:0] fa0, fb0, fc0;
  logic [4:0]  ff0;

  logic        busy1, done1, pass1;
  logic [7:0]  err1, fop1;
  logic [15:0] fa1, fb1, fc1;
  logic [4:0]  ff1;

  // mode 0 good, 1 ADD+1, 2 XOR bit0 stuck 0, 3 always wrong
  function automatic logic [15:0] alu_f(
    input logic [15:0] a, input logic [15:0] b,
    input logic [7:0] op, input int mode);
    logic [15:0] r;
    case (op)
      8'h05: r = a + b;
      8'h01: r = a & b;
      8'h02: r = a | b;
      8'h03: r = a ^ b;
      default: r = 16'h0;
    endcase
    if (mode == 1 && op == 8'h05) r = r + 16'h1;
    if (mode == 2 && op == 8'h03) r = r & 16'hFFFE;
    if (mode == 3) r = ~r;
    return r;
  endfunction

  assign if0.alu_c = alu_f(if0.alu_a, if0.alu_b, if0.alu_opcode, mode0);
  assign if0.alu_flags = if0.alu_c[4:0];
  assign if1.alu_c = alu_f(if1.alu_a, if1.alu_b, if1.alu_opcode, mode1);
  assign if1.alu_flags = if1.alu_c[4:0];

  alu_self_checker u0 (
    .clk(clk), .reset(reset), .start(start0), .alu(if0.master),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_a(fa0), .fail_b(fb0), .fail_c(fc0), .fail_op(fop0),
    .fail_flags(ff0)
  );

  alu_self_checker #(.VECTORS_PER_OP(255), .SEED(16'h0000)) u1 (
    .clk(clk), .reset(reset), .start(start1), .alu(if1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_a(fa1), .fail_b(fb1), .fail_c(fc1), .fail_op(fop1),
    .fail_flags(ff1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulses start, counts busy cycles, captures vector 4 operands.
  task automatic run_pass(input int which, input int poke,
                          output int cyc, output logic [15:0] ca,
                          output logic [15:0] cb);
    logic b;
    cyc = 0; ca = 16'h0; cb = 16'h0;
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    b = (which == 0) ? busy0 : busy1;
    while (b && cyc < 5000) begin
      cyc++;
      if (cyc == 14) begin
        ca = (which == 0) ? if0.alu_a : if1.alu_a;
        cb = (which == 0) ? if0.alu_b : if1.alu_b;
      end
      if (which == 0) start0 = (cyc == poke);
      else start1 = (cyc == poke);
      @(negedge clk);
      b = (which == 0) ? busy0 : busy1;
    end
    start0 = 1'b0; start1 = 1'b0;
  endtask

  typedef struct {
    int          mode;
    int          poke;
    int          exp_err;
    bit          exp_pass;
    logic [7:0]  fop;
    logic [15:0] fa, fb, fc;
    logic [4:0]  ff;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int          cyc;
    logic [15:0] ca, cb;

    tbl[0] = '{0, 0,   0, 1'b1, 8'h00, 16'h0000, 16'h0000, 16'h0000, 5'h00};
    tbl[1] = '{1, 0,  20, 1'b0, 8'h05, 16'h0000, 16'h0000, 16'h0001, 5'h01};
    tbl[2] = '{2, 100, -1, 1'b0, 8'h03, 16'h0000, 16'hFFFF, 16'hFFFE, 5'h1E};
    tbl[3] = '{3, 0,  80, 1'b0, 8'h05, 16'h0000, 16'h0000, 16'hFFFF, 5'h1F};
    tbl[4] = '{0, 0,   0, 1'b1, 8'h00, 16'h0000, 16'h0000, 16'h0000, 5'h00};

    reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    mode0 = 0; mode1 = 0;
    repeat (3) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_pass", pass0, 1'b0);
    chk("rst_err", err0, 8'h00);
    chk("rst_alu_a", if0.alu_a, 16'h0000);
    chk("rst_alu_op", if0.alu_opcode, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      mode0 = tbl[i].mode;
      run_pass(0, tbl[i].poke, cyc, ca, cb);
      chk($sformatf("v%0d_cycles", i), cyc, 240);
      chk($sformatf("v%0d_rand_a", i), ca, 16'hACE1);
      chk($sformatf("v%0d_rand_b", i), cb, 16'hE270);
      chk($sformatf("v%0d_done", i), done0, 1'b1);
      chk($sformatf("v%0d_pass", i), pass0, tbl[i].exp_pass);
      if (tbl[i].exp_err >= 0)
        chk($sformatf("v%0d_err", i), err0, tbl[i].exp_err);
      else
        chk($sformatf("v%0d_err_nz", i), err0 != 8'h0, 1'b1);
      chk($sformatf("v%0d_fop", i), fop0, tbl[i].fop);
      chk($sformatf("v%0d_fa", i), fa0, tbl[i].fa);
      chk($sformatf("v%0d_fb", i), fb0, tbl[i].fb);
      chk($sformatf("v%0d_fc", i), fc0, tbl[i].fc);
      chk($sformatf("v%0d_ff", i), ff0, tbl[i].ff);
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_hold_done", i), done0, 1'b1);
      chk($sformatf("v%0d_hold_busy", i), busy0, 1'b0);
    end

    // abort a failing pass with reset after 50 cycles
    mode0 = 3;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (49) @(negedge clk);
    chk("abort_busy_pre", busy0, 1'b1);
    chk("abort_err_pre", err0 != 8'h0, 1'b1);
    reset = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start0 = 1'b0;
    chk("abort_busy", busy0, 1'b0);
    chk("abort_done", done0, 1'b0);
    chk("abort_pass", pass0, 1'b0);
    chk("abort_err", err0, 8'h00);
    chk("abort_alu_a", if0.alu_a, 16'h0000);
    chk("abort_fop", fop0, 8'h00);
    mode0 = 0;
    @(negedge clk);
    run_pass(0, 0, cyc, ca, cb);
    chk("after_abort_cycles", cyc, 240);
    chk("after_abort_pass", pass0, 1'b1);

    // SEED=0 and saturation on the long instance
    mode1 = 3;
    run_pass(1, 0, cyc, ca, cb);
    chk("sat_cycles", cyc, 3108);
    chk("seed0_rand_a", ca, 16'h0001);
    chk("seed0_rand_b", cb, 16'hB400);
    chk("sat_err", err1, 8'hFF);
    chk("sat_done", done1, 1'b1);
    chk("sat_pass", pass1, 1'b0);
    chk("sat_fop", fop1, 8'h05);
    chk("sat_fc", fc1, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
